// File: rtl/spw_tx_pkg.sv
// Shared definitions for the SpaceWire transmit FIFO: N-char format,
// control codes, default geometry and occupancy-update encoding.
package spw_tx_pkg;

  localparam int NCHAR_W = 9;

  typedef logic [NCHAR_W-1:0] nchar_t;

  // Bit 8 set marks a control character; these are the two end-of-packet codes.
  localparam nchar_t NCHAR_EOP = 9'h100;
  localparam nchar_t NCHAR_EEP = 9'h101;

  localparam int FIFO_DEPTH_DEF  = 64;
  localparam int FIFO_AWIDTH_DEF = 6;
  localparam int AFULL_MARGIN    = 8;

  // How the memory occupancy changes at an edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  // A push and a load in the same cycle cancel out.
  function automatic cnt_op_t cnt_op(input logic push, input logic load);
    cnt_op_t op;
    op = CNT_HOLD;
    if (push && !load) op = CNT_INC;
    if (!push && load) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/spw_fifo_ram.sv
// Simple dual-port storage for the transmit FIFO: synchronous write,
// asynchronous read so the caller can register the word in its output stage.
module spw_fifo_ram
  import spw_tx_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int AWIDTH = FIFO_AWIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AWIDTH-1:0]  i_waddr,
  input  logic [NCHAR_W-1:0] i_wdata,
  input  logic [AWIDTH-1:0]  i_raddr,
  output logic [NCHAR_W-1:0] o_rdata
);

  logic [NCHAR_W-1:0] r_mem [DEPTH];

  // Store the pushed N-char; contents are intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_fifo_spw.sv
// Transmit-side FIFO between the host and the SpaceWire transmitter.
// Host pushes N-chars into memory; a single output register presents one
// N-char at a time to the transmitter with a valid/ready style handshake.
module tx_fifo_spw
  import spw_tx_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int AWIDTH = FIFO_AWIDTH_DEF
) (
  input  logic               pclk_tx,
  input  logic               reset_tx_n,
  input  logic               wr_en_fifo,
  input  logic [NCHAR_W-1:0] wr_data_fifo,
  input  logic               flush_fifo,
  input  logic               enable_tx,
  input  logic               ready_tx_data,
  output logic [NCHAR_W-1:0] data_tx_o,
  output logic               txwrite_tx,
  output logic               full_fifo,
  output logic               almost_full_fifo,
  output logic               empty_fifo,
  output logic [AWIDTH:0]    counter_fifo,
  output logic               overflow_fifo
);

  localparam int AFULL_LVL = (DEPTH > AFULL_MARGIN) ? (DEPTH - AFULL_MARGIN) : 0;
  localparam logic [AWIDTH:0] C_FULL  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] C_AFULL = (AWIDTH+1)'(AFULL_LVL);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [AWIDTH-1:0]  r_wr_ptr;
  logic [AWIDTH-1:0]  r_rd_ptr;
  logic [AWIDTH:0]    r_count;
  logic [NCHAR_W-1:0] r_data_out;
  logic               r_txwrite;
  logic               r_overflow;

  logic               w_full;
  logic               w_push;
  logic               w_stage_free;
  logic               w_load;
  logic               w_xfer_done;
  logic [NCHAR_W-1:0] w_rd_data;
  cnt_op_t            w_cnt_op;

  // Assert reset immediately, release it only on a clock edge.
  always_ff @(posedge pclk_tx or negedge reset_tx_n) begin
    if (!reset_tx_n) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Full is taken from the occupancy counter, never from pointer equality.
  assign w_full       = (r_count == C_FULL);
  assign w_push       = wr_en_fifo && !w_full && !flush_fifo;
  // Output register may refill when empty or when its word leaves this cycle.
  assign w_stage_free = !r_txwrite || ready_tx_data;
  assign w_load       = enable_tx && !flush_fifo && (r_count != '0) && w_stage_free;
  // While the link is halted the presented word is held, not consumed.
  assign w_xfer_done  = enable_tx && r_txwrite && ready_tx_data;
  assign w_cnt_op     = cnt_op(w_push, w_load);

  spw_fifo_ram #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .i_clk   (pclk_tx),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data_fifo),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Pointers and occupancy; flush wins over push and load.
  always_ff @(posedge pclk_tx or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_fifo) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + 1'b1;
        CNT_DEC: r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load from memory, hold while stalled, empty after transfer.
  always_ff @(posedge pclk_tx or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data_out <= '0;
      r_txwrite  <= 1'b0;
    end else if (flush_fifo) begin
      r_data_out <= '0;
      r_txwrite  <= 1'b0;
    end else if (w_load) begin
      r_data_out <= w_rd_data;
      r_txwrite  <= 1'b1;
    end else if (w_xfer_done) begin
      r_txwrite  <= 1'b0;
    end
  end

  // Sticky overflow: a push attempted against a full memory is dropped.
  always_ff @(posedge pclk_tx or negedge w_rst_n) begin
    if (!w_rst_n)                     r_overflow <= 1'b0;
    else if (flush_fifo)              r_overflow <= 1'b0;
    else if (wr_en_fifo && w_full)    r_overflow <= 1'b1;
  end

  assign data_tx_o        = r_data_out;
  assign txwrite_tx       = r_txwrite;
  assign counter_fifo     = r_count;
  assign full_fifo        = w_full;
  assign almost_full_fifo = (r_count >= C_AFULL);
  assign empty_fifo       = (r_count == '0) && !r_txwrite;
  assign overflow_fifo    = r_overflow;

endmodule

// File: tb/tb_tx_fifo_spw.sv
// Directed bench for tx_fifo_spw: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/overflow, paced drain, streaming,
// flush and asynchronous reset.
module tb_tx_fifo_spw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       flush;
  logic       en;
  logic       rdy;
  logic [8:0] data_o;
  logic       txw;
  logic       full, afull, empty, ovf;
  logic [6:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       stall_prev = 1'b0;
  logic [8:0] data_prev = '0;

  always #5 clk = ~clk;

  tx_fifo_spw #(.DEPTH(64), .AWIDTH(6)) dut (
    .pclk_tx          (clk),
    .reset_tx_n       (rst_n),
    .wr_en_fifo       (wr_en),
    .wr_data_fifo     (wr_data),
    .flush_fifo       (flush),
    .enable_tx        (en),
    .ready_tx_data    (rdy),
    .data_tx_o        (data_o),
    .txwrite_tx       (txw),
    .full_fifo        (full),
    .almost_full_fifo (afull),
    .empty_fifo       (empty),
    .counter_fifo     (cnt),
    .overflow_fifo    (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " count"}, 32'(cnt), 0);
    chk({tag, " txwrite"}, 32'(txw), 0);
    chk({tag, " data"}, 32'(data_o), 0);
    chk({tag, " overflow"}, 32'(ovf), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " afull"}, 32'(afull), 0);
    chk({tag, " empty"}, 32'(empty), 1);
  endtask

  // Scoreboard: on each falling edge, a presented word with ready high will
  // leave at the next rising edge; a stalled word must not change.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) chk("hold_stable", 32'(data_o), 32'(data_prev));
      if (txw && rdy) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(data_o), 32'h1ff);
        else chk("stream_order", 32'(data_o), 32'(exp_q.pop_front()));
      end
      stall_prev = txw && !rdy;
      data_prev  = data_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  typedef struct {
    logic       wr;
    logic [8:0] wd;
    logic       fl;
    logic       en;
    logic       rd;
    logic [8:0] d;
    logic       tw;
    logic [6:0] c;
    logic       em;
    logic       cd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; en = 1'b0; rdy = 1'b0;
    //            wr  wd       fl en rd  d        tw c     em cd
    vecs[0]  = '{1'b1, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 7'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b1, 7'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 7'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 9'h100, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 7'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 9'h101, 1'b0, 1'b1, 1'b0, 9'h100, 1'b1, 7'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 9'h100, 1'b1, 7'd1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h101, 1'b1, 7'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h101, 1'b1, 7'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 7'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 9'h055, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 7'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 7'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 7'd0, 1'b1, 1'b1};

    // Reset and release; allow the internal release path to settle.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_reset_vals("reset");

    // Single-cycle behaviour from the vector table.
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].wd; flush = vecs[i].fl;
      en = vecs[i].en; rdy = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d txwrite", i), 32'(txw), 32'(vecs[i].tw));
      chk($sformatf("vec%0d count", i), 32'(cnt), 32'(vecs[i].c));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].em));
      if (vecs[i].cd) chk($sformatf("vec%0d data", i), 32'(data_o), 32'(vecs[i].d));
    end
    wr_en = 1'b0; flush = 1'b0;

    // Fill with the link halted, then one push too many.
    en = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_data = 9'(i);
      exp_q.push_back(9'(i));
      tick();
      chk($sformatf("fill%0d count", i), 32'(cnt), 32'(i + 1));
      chk($sformatf("fill%0d afull", i), 32'(afull), 32'((i + 1) >= 56));
      chk($sformatf("fill%0d full", i), 32'(full), 32'((i + 1) == 64));
    end
    wr_data = 9'h1AA;
    tick();
    wr_en = 1'b0;
    chk("overflow_set", 32'(ovf), 1);
    chk("overflow_count", 32'(cnt), 64);
    chk("overflow_full", 32'(full), 1);
    chk("overflow_txwrite", 32'(txw), 0);

    // Drain with ready toggling; scoreboard checks order and stall stability.
    begin
      bit done = 1'b0;
      mon_en = 1'b1; en = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
        rdy = c[0];
        tick();
        if (exp_q.size() == 0 && !txw) done = 1'b1;
      end
      mon_en = 1'b0;
      chk("drain_timeout", 32'(done), 1);
      chk("drain_leftover", 32'(exp_q.size()), 0);
      chk("drain_empty", 32'(empty), 1);
      chk("drain_count", 32'(cnt), 0);
      chk("overflow_sticky", 32'(ovf), 1);
    end

    // Flush with ten stored words and a word presented.
    en = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 9'(9'h020 + i);
      tick();
    end
    wr_en = 1'b0; en = 1'b1;
    tick();
    chk("preflush_txwrite", 32'(txw), 1);
    chk("preflush_count", 32'(cnt), 9);
    chk("preflush_data", 32'(data_o), 32'h020);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(cnt), 0);
    chk("flush_txwrite", 32'(txw), 0);
    chk("flush_overflow", 32'(ovf), 0);
    chk("flush_data", 32'(data_o), 0);
    chk("flush_empty", 32'(empty), 1);

    // Push and pop every cycle; pointers wrap several times.
    exp_q.delete();
    en = 1'b1; rdy = 1'b1; mon_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      logic [8:0] w;
      w = ((k % 16) == 15) ? 9'h100 : {1'b0, 8'(k)};
      wr_en = 1'b1; wr_data = w;
      exp_q.push_back(w);
      tick();
      chk($sformatf("stream%0d count", k), 32'(cnt), 1);
      if (k >= 1) chk($sformatf("stream%0d txwrite", k), 32'(txw), 1);
    end
    wr_en = 1'b0;
    begin
      bit done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        tick();
        if (exp_q.size() == 0 && !txw) done = 1'b1;
      end
      chk("stream_drain_timeout", 32'(done), 1);
    end
    mon_en = 1'b0;

    // Asynchronous reset between edges with five stored words.
    en = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 9'(9'h040 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("prereset_count", 32'(cnt), 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk_reset_vals("post_reset");
    en = 1'b1; rdy = 1'b1;
    wr_en = 1'b1; wr_data = 9'h101;
    tick();
    wr_en = 1'b0;
    chk("eep_count", 32'(cnt), 1);
    chk("eep_latency_txwrite", 32'(txw), 0);
    tick();
    chk("eep_txwrite", 32'(txw), 1);
    chk("eep_data", 32'(data_o), 32'h101);
    chk("eep_count_after_load", 32'(cnt), 0);
    tick();
    chk("eep_alone_txwrite", 32'(txw), 0);
    chk("eep_alone_empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
